// File: rtl/cpu6502_pkg.sv
// Shared 6502 core types: datapath control bundle, interrupt kinds,
// sequencer states and interrupt vector low bytes.
package cpu6502_pkg;

  // Datapath controls driven by the interrupt sequencer while it owns the bus.
  // ADL/ADH precharge to 1s; the z_* pulls clear individual bits.
  typedef struct packed {
    logic i_pc;      // increment PC
    logic s_adl;     // stack pointer onto ADL
    logic adl_abl;   // ADL onto address bus low
    logic z_adh7_1;  // pull ADH[7:1] low -> page 0x01
    logic adh_abh;   // ADH onto address bus high
    logic pch_db;    // PCH onto data bus
    logic pcl_db;    // PCL onto data bus
    logic p_db;      // P onto data bus
    logic dl_db;     // data latch onto data bus
    logic dl_adl;    // data latch onto ADL
    logic adl_pcl;   // ADL into PCL
    logic dl_adh;    // data latch onto ADH
    logic adh_pch;   // ADH into PCH
    logic z_adl0;    // pull ADL[0] low
    logic z_adl1;    // pull ADL[1] low
    logic z_adl2;    // pull ADL[2] low
  } control_signals_t;

  typedef enum logic [1:0] {K_RESET, K_NMI, K_IRQ, K_BRK} int_kind_e;

  typedef enum logic [2:0] {
    S_IDLE, S_T0, S_T1, S_PUSH_PCH, S_PUSH_PCL, S_PUSH_P, S_VEC_LO, S_VEC_HI
  } seq_state_e;

  localparam logic [7:0] VEC_LO_NMI   = 8'hFA;
  localparam logic [7:0] VEC_LO_RESET = 8'hFC;
  localparam logic [7:0] VEC_LO_IRQ   = 8'hFE;

  // Vector low byte for an interrupt kind (IRQ and BRK share a vector).
  function automatic logic [7:0] vec_lo(int_kind_e k);
    case (k)
      K_NMI:   return VEC_LO_NMI;
      K_RESET: return VEC_LO_RESET;
      default: return VEC_LO_IRQ;
    endcase
  endfunction

endpackage

// File: rtl/nmi_edge_detect.sv
// NMI pin synchronizer, falling-edge detector and pending latch.
module nmi_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic nmi_n,
  input  logic clr,
  output logic pend,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // A new edge in the same cycle as a clear wins, so it is never dropped.
  assign fall = prev_q & ~sync_q[STAGES-1];

  // Synchronize the pin (idle high) and latch a pending NMI on each falling edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
      pend   <= 1'b0;
    end else begin
      sync_q <= STAGES'({sync_q, nmi_n});
      prev_q <= sync_q[STAGES-1];
      pend   <= fall | (pend & ~clr);
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// Seven-cycle RESET/NMI/IRQ/BRK entry sequencer for the 6502 core.
// Owns the control bus while active; outputs are registered from the
// next-state encode so they change cleanly on the clock edge.
import cpu6502_pkg::*;

module interrupt_sequencer #(
  parameter int NMI_SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             nmi_n,
  input  logic             irq_n,
  input  logic             i_flag,
  input  logic             sync,
  input  logic             brk,
  input  logic             rdy,
  output logic             active,
  output control_signals_t ctl,
  output logic             rw,
  output logic             s_dec,
  output logic             set_i,
  output logic             b_push
);

  seq_state_e                 state, state_n;
  int_kind_e                  kind, kind_n;
  logic [NMI_SYNC_STAGES-1:0] irq_sync;
  logic nmi_pend, nmi_fall, nmi_clr, irq_req;
  logic push, adv, push_n;
  control_signals_t ctl_n;

  nmi_edge_detect #(.STAGES(NMI_SYNC_STAGES)) u_nmi (
    .clk     (clk),
    .reset_n (reset_n),
    .nmi_n   (nmi_n),
    .clr     (nmi_clr),
    .pend    (nmi_pend),
    .fall    (nmi_fall)
  );

  // IRQ pin synchronizer, reset to the inactive level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_sync <= '1;
    else          irq_sync <= NMI_SYNC_STAGES'({irq_sync, irq_n});
  end

  assign irq_req = !irq_sync[NMI_SYNC_STAGES-1] && !i_flag;

  // Push cycles are writes (ignore rdy) except during RESET, where they are reads.
  assign push = (state == S_PUSH_PCH) || (state == S_PUSH_PCL) || (state == S_PUSH_P);
  assign adv  = rdy || (push && kind != K_RESET);

  function automatic control_signals_t ctl_encode(seq_state_e s, int_kind_e k);
    control_signals_t c;
    logic [2:0]       pull;
    c    = '0;
    pull = 3'(~vec_lo(k));
    case (s)
      S_T0: c.i_pc = (k == K_BRK);
      S_PUSH_PCH, S_PUSH_PCL, S_PUSH_P: begin
        c.s_adl    = 1'b1;
        c.adl_abl  = 1'b1;
        c.z_adh7_1 = 1'b1;
        c.adh_abh  = 1'b1;
        c.pch_db   = (s == S_PUSH_PCH);
        c.pcl_db   = (s == S_PUSH_PCL);
        c.p_db     = (s == S_PUSH_P);
      end
      S_VEC_LO: begin
        c.adl_abl = 1'b1;
        c.adh_abh = 1'b1;
        c.z_adl0  = pull[0];
        c.z_adl1  = pull[1];
        c.z_adl2  = pull[2];
        c.dl_db   = 1'b1;
        c.dl_adl  = 1'b1;
        c.adl_pcl = 1'b1;
      end
      S_VEC_HI: begin
        c.adl_abl = 1'b1;
        c.adh_abh = 1'b1;
        c.z_adl1  = pull[1];
        c.z_adl2  = pull[2];
        c.dl_adh  = 1'b1;
        c.adh_pch = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  // Next state/kind, NMI hijack at VEC_LO entry, and NMI consume on VEC_LO issue
  always_comb begin
    state_n = state;
    kind_n  = kind;
    nmi_clr = 1'b0;
    case (state)
      S_IDLE: if (sync) begin
        if (nmi_pend)     begin state_n = S_T0; kind_n = K_NMI; end
        else if (irq_req) begin state_n = S_T0; kind_n = K_IRQ; end
        else if (brk)     begin state_n = S_T0; kind_n = K_BRK; end
      end
      S_T0:       if (adv) state_n = S_T1;
      S_T1:       if (adv) state_n = S_PUSH_PCH;
      S_PUSH_PCH: if (adv) state_n = S_PUSH_PCL;
      S_PUSH_PCL: if (adv) state_n = S_PUSH_P;
      S_PUSH_P: if (adv) begin
        state_n = S_VEC_LO;
        if ((kind == K_IRQ || kind == K_BRK) && (nmi_pend || nmi_fall)) kind_n = K_NMI;
      end
      S_VEC_LO: if (adv) begin
        state_n = S_VEC_HI;
        nmi_clr = (kind == K_NMI);
      end
      S_VEC_HI:   if (adv) state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
    push_n = (state_n == S_PUSH_PCH) || (state_n == S_PUSH_PCL) || (state_n == S_PUSH_P);
    ctl_n  = ctl_encode(state_n, kind_n);
  end

  // FSM state plus registered bus outputs for the state being entered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_T0;
      kind   <= K_RESET;
      active <= 1'b1;
      ctl    <= '0;
      rw     <= 1'b1;
      s_dec  <= 1'b0;
      set_i  <= 1'b0;
      b_push <= 1'b0;
    end else begin
      state  <= state_n;
      kind   <= kind_n;
      active <= (state_n != S_IDLE);
      ctl    <= ctl_n;
      rw     <= !(push_n && kind_n != K_RESET);
      s_dec  <= push_n;
      set_i  <= (state_n == S_VEC_LO);
      b_push <= (state_n == S_PUSH_P) && (kind_n == K_BRK);
    end
  end

endmodule

// File: doc/interrupt_sequencer.md
# interrupt_sequencer

Sequencer for the 6502 core's interrupt entry sequence. It takes over the control-signal bus for the seven-cycle RESET/NMI/IRQ/BRK sequence, handling stack pushes, I-flag set and vector fetch. It sits beside the instruction decoder: on any cycle where `active=1`, its `ctl` output is muxed onto the datapath in place of the decoder's. It owns NMI edge detection, IRQ masking, NMI hijack of IRQ/BRK, and the power-on reset sequence.

## Interface
Parameters:
- `NMI_SYNC_STAGES`, default 2: synchronizer depth on `nmi_n`/`irq_n` (≥1).

Ports:
- `clk`  in  1  core clock, single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `nmi_n`  in  1  NMI pin, falling-edge triggered.
- `irq_n`  in  1  IRQ pin, level, active low.
- `i_flag`  in  1  current P.I.
- `sync`  in  1  decoder is at an instruction boundary; opcode fetch is this cycle.
- `brk`  in  1  decoder decoded BRK; sampled with `sync` one fetch later.
- `rdy`  in  1  bus ready; low stalls read cycles.
- `active`  out  1  sequencer owns `ctl`/`rw`.
- `ctl`  out  control_signals_t  datapath controls while `active`.
- `rw`  out  1  1=read, 0=write.
- `s_dec`  out  1  stack-pointer decrement strobe.
- `set_i`  out  1  set P.I this cycle.
- `b_push`  out  1  value of B bit in pushed P.

## Operation
- Undriven ADL/ADH precharge to 1s. Stack page 0x01 = `z_adh7_1` only. Vectors: ADH=0xFF with no pulls. ADL = 0xFA (NMI: `z_adl0`,`z_adl2`), 0xFC (RESET: `z_adl0`,`z_adl1`), 0xFE (IRQ/BRK: `z_adl0`); hi byte drops `z_adl0`.
- `nmi_pend` sets on a synchronized 1→0 of `nmi_n` and clears when the NMI vector-lo fetch issues.
- `irq_req = !irq_n_sync && !i_flag`.
- On `sync=1` with `nmi_pend` or `irq_req`, kind latches in priority NMI > IRQ and the sequence starts next cycle. BRK is the same path, entered via `brk`.
- States and outputs:
  - IDLE: `active=0`, `ctl`=0.
  - T0: dummy read at PC, `i_pc=0` for hardware interrupts, `i_pc=1` for BRK.
  - T1: dummy read at PC, `i_pc=0`.
  - PUSH_PCH: `s_adl`,`adl_abl`,`z_adh7_1`,`adh_abh`,`pch_db`; `rw=0`; `s_dec`.
  - PUSH_PCL: as PUSH_PCH but with `pcl_db`.
  - PUSH_P: as PUSH_PCH but with `p_db`; `b_push`=1 only for BRK.
  - VEC_LO: vector-lo address, `dl_db`→PCL via `dl_adl`,`adl_pcl`; `set_i`.
  - VEC_HI: vector-hi address, `dl_adh`,`adh_pch`.
  - Then back to IDLE; the next cycle is the decoder's fetch.
- RESET kind: `rw` is forced to 1 in all PUSH states (reads, no writes), but `s_dec` still pulses.
- NMI hijack: if `nmi_pend` is set on or before entry to VEC_LO during IRQ/BRK, the kind switches to NMI and the NMI vector is used. A later edge stays pending.

## Timing
- While `reset_n`=0: state=T0, kind=RESET, `active=1`, `ctl`=0, `rw=1`, `s_dec=0`, `set_i=0`, `b_push=0`, `nmi_pend=0`.
- After release, the first fetch is 7 cycles later, at `[$FFFD:$FFFC]`.
- Entry latency: the `sync` cycle, then 7 active cycles. Total 8 cycles from an interrupt-taking `sync` to the vectored fetch.
- Pin-to-recognition latency is `NMI_SYNC_STAGES` cycles.
- `rdy=0` in a read state (T0, T1, VEC_*, RESET pushes) holds state and outputs. `rdy` is ignored in write cycles.
- A `sync` while `active` is ignored.
- `reset_n` asserted mid-sequence aborts to the reset state; any pending NMI is lost.

## Structure
- The shared package `cpu6502_pkg` holds `control_signals_t`, the `int_kind_e` enum (RESET, NMI, IRQ, BRK), the `seq_state_e` enum, and the vector-low constants 0xFA/0xFC/0xFE.
- Sub-module `nmi_edge_detect` contains the synchronizer, falling-edge detect and pending latch, with a clear input.
- The top level holds the FSM and a combinational `ctl` encode per state.

## Test plan
- Reset release → 7 active cycles with `rw=1` throughout; 3 `s_dec` pulses; VEC_LO/VEC_HI at 0xFFFC/0xFFFD; `set_i` pulses once; `active` falls.
- `irq_n`=0, `i_flag`=0, `sync` → pushes to 0x01xx with `rw=0`, `b_push=0`, vector 0xFFFE. Repeat with `i_flag`=1 → no entry.
- BRK with `sync` → T0 has `i_pc=1`, `b_push=1`, vector 0xFFFE.
- IRQ sequence with an `nmi_n` falling edge recognized during PUSH_PCL → vector 0xFFFA and `nmi_pend` cleared. An edge after VEC_LO → a second NMI entry at the next `sync`.
- `rdy=0` for 3 cycles in T1 and in PUSH_P → T1 extends 3 cycles; PUSH_P does not extend.
- `reset_n` pulsed low during PUSH_PCL → outputs at reset values immediately; a fresh reset sequence follows.
